seg7_reader: RTL
================

// Module: seg7_reader
// PURPOSE
// Receive end of the 7-segment interface: samples raw segment lines {a..g} and filters glitches.
// Decodes each stable pattern back to its 4-bit hex digit and hands it to a consumer over valid/ready.
// Sits on the display-monitor path, where it checks or reads back what the hex-to-segment driver emits.
// PARAMETERS
// STABLE_CYCLES  4  consecutive identical samples required before a pattern is accepted (>=2)
// PORTS
// clk      in   1  single clock, rising edge
// rst_n    in   1  synchronous reset, active low
// en       in   1  sampling enable
// a..g     in   1 each  segment lines, active high; pattern order is {a,b,c,d,e,f,g}
// ready    in   1  consumer accepts digit this cycle when valid=1
// digit    out  4  decoded hex value (0 when err=1)
// valid    out  1  digit/err hold a result not yet accepted
// err      out  1  qualifies digit: stable pattern is not a legal hex glyph
// blank    out  1  level: current stable pattern is 7'b0000000
// overrun  out  1  sticky: an unaccepted result was overwritten
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): all outputs 0, state IDLE, counter 0, sample regs 0; reset mid-stream drops any pending result.
// - Glyph table {a..g}:
//   0=1111110 1=0110000 2=1101101 3=1111001 4=0110011 5=1011011 6=1011111 7=1110000
//   8=1111111 9=1111011 A=1110111 b=0011111 C=1001110 d=0111101 E=1001111 F=1000111
// - Input is registered once (sample reg); all decisions use registered samples only.
// - States: IDLE (en=0) -> TRACK (counting stability) -> LOCKED (pattern reported).
//   IDLE: counter 0, no events; en=1 -> TRACK.
//   TRACK: sample==previous sample -> cnt++; else cnt=1.
//     When cnt reaches STABLE_CYCLES -> raise event -> LOCKED.
//   LOCKED: sample!=previous sample -> TRACK with cnt=1; identical -> stay, no further events.
//   en=0 in any state -> IDLE next cycle; a pending valid result is kept, not cleared.
// - Counter saturates; width $clog2(STABLE_CYCLES+1).
// - Latency: input held constant from before edge 0 with en=1 -> valid=1 visible after edge STABLE_CYCLES.
// - Event, legal glyph: digit=value, err=0, valid=1.
// - Event, all-zero pattern: no valid; blank=1 until the next event; any other event clears blank.
// - Event, illegal non-zero pattern: digit=0, err=1, valid=1.
// - Handshake: valid stays high until the cycle valid&&ready; then valid=0 next edge.
//   digit/err remain stable while valid=1 unless overwritten.
// - Event with valid=1 and ready=0: load new result, keep valid=1, set overrun (cleared only by reset).
// - Event in the same cycle as valid&&ready: load new result, valid stays 1, no overrun.
// - Glitch shorter than STABLE_CYCLES followed by a return to the same glyph:
//   the glyph is reported again once it is stable (no dedup).
// STRUCTURE
// - Shared package seg7_pkg: localparams SEG_0..SEG_F and SEG_BLANK (7-bit, {a..g});
//   state encoding IDLE/TRACK/LOCKED. The hex-to-segment driver uses the same constants.
// - One combinational sub-module seg7_pattern_lut:
//   in pattern[6:0] -> out hit, digit[3:0]; implemented as a full case over the 16 glyphs, default hit=0.
// - Top level holds the sample/prev regs, stability counter, FSM and output holding register.
// TESTING
// 1. Reset: drive rst_n=0 for 2 cycles with random a..g -> all outputs 0; valid stays 0 during reset.
// 2. Steady 7'b1101101, en=1, ready=1 -> valid pulses 1 cycle after edge 4, digit=2, err=0; no repeat while held.
// 3. Glitch: 1011011 for 3 cycles, then 1110000 held -> no result for 5; one result digit=7 after 4 stable samples.
// 4. Illegal 7'b1000000 held -> valid=1, err=1, digit=0; then 0000000 held -> blank=1, no valid.
// 5. Backpressure: ready=0, present 0110011 then 0111101, each stable 5 cycles
//    -> digit=4 held, then overwritten by digit=D, overrun=1; ready=1 -> valid drops next edge, overrun stays 1.
// 6. en dropped mid-count (cycle 2 of 4) and mid-pending valid -> no event during en=0;
//    pending result retained; counting restarts from 1 on en=1.
// 7. Sweep all 16 glyphs with ready=1 -> digits 0..F in order, err=0 throughout; compare against seg7_pkg.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: constants shared by the 7-segment driver and the reader.
//   SEG_0..SEG_F : segment glyphs, bit order {a,b,c,d,e,f,g}, active high
//   SEG_BLANK    : all segments off
//   state_t      : reader FSM state encoding
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1111110;
  localparam logic [6:0] SEG_1     = 7'b0110000;
  localparam logic [6:0] SEG_2     = 7'b1101101;
  localparam logic [6:0] SEG_3     = 7'b1111001;
  localparam logic [6:0] SEG_4     = 7'b0110011;
  localparam logic [6:0] SEG_5     = 7'b1011011;
  localparam logic [6:0] SEG_6     = 7'b1011111;
  localparam logic [6:0] SEG_7     = 7'b1110000;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1111011;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b0011111;
  localparam logic [6:0] SEG_C     = 7'b1001110;
  localparam logic [6:0] SEG_D     = 7'b0111101;
  localparam logic [6:0] SEG_E     = 7'b1001111;
  localparam logic [6:0] SEG_F     = 7'b1000111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_lut.sv
// seg7_pattern_lut: combinational glyph-to-hex decode.
//   pattern [6:0] in  : segment pattern {a..g}
//   hit         out : pattern is one of the 16 hex glyphs
//   digit [3:0] out : decoded value, 0 when hit=0
module seg7_pattern_lut
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       hit,
  output logic [3:0] digit
);

  always_comb begin
    hit   = 1'b1;
    digit = 4'h0;
    case (pattern)
      SEG_0:   digit = 4'h0;
      SEG_1:   digit = 4'h1;
      SEG_2:   digit = 4'h2;
      SEG_3:   digit = 4'h3;
      SEG_4:   digit = 4'h4;
      SEG_5:   digit = 4'h5;
      SEG_6:   digit = 4'h6;
      SEG_7:   digit = 4'h7;
      SEG_8:   digit = 4'h8;
      SEG_9:   digit = 4'h9;
      SEG_A:   digit = 4'hA;
      SEG_B:   digit = 4'hB;
      SEG_C:   digit = 4'hC;
      SEG_D:   digit = 4'hD;
      SEG_E:   digit = 4'hE;
      SEG_F:   digit = 4'hF;
      default: begin
        hit   = 1'b0;
        digit = 4'h0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: samples raw segment lines, filters glitches, decodes stable
// patterns to hex digits and offers them over valid/ready.
//   clk, rst_n     : clock, synchronous active-low reset
//   en             : sampling enable
//   a..g           : segment lines, active high
//   ready          : consumer accepts digit when valid=1
//   digit [3:0]    : decoded value (0 when err=1)
//   valid          : result pending
//   err            : stable pattern was not a hex glyph
//   blank          : last stable pattern was all-off
//   overrun        : sticky, a pending result was overwritten
//
// state  | meaning
// IDLE   | en=0, counter cleared, no events
// TRACK  | counting consecutive identical samples
// LOCKED | current pattern already reported, waiting for a change
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  input  logic       ready,
  output logic [3:0] digit,
  output logic       valid,
  output logic       err,
  output logic       blank,
  output logic       overrun
);

  localparam int             CW         = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_TARGET = CW'(STABLE_CYCLES);

  logic [6:0]    r_sample;
  logic [6:0]    r_prev;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  state_t        r_state;
  state_t        w_state_next;
  logic          w_same;
  logic          w_event;
  logic          w_hit;
  logic [3:0]    w_lut_digit;
  logic [3:0]    r_digit;
  logic          r_valid;
  logic          r_err;
  logic          r_blank;
  logic          r_overrun;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sample <= 7'b0;
      r_prev   <= 7'b0;
    end else begin
      r_sample <= {a, b, c, d, e, f, g};
      r_prev   <= r_sample;
    end
  end

  assign w_same = (r_sample == r_prev);

  seg7_pattern_lut u_lut (
    .pattern (r_sample),
    .hit     (w_hit),
    .digit   (w_lut_digit)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (!en) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE:    w_state_next = TRACK;
        TRACK:   if (w_cnt_next == CNT_TARGET) w_state_next = LOCKED;
        LOCKED:  if (!w_same) w_state_next = TRACK;
        default: w_state_next = IDLE;
      endcase
    end
  end

  // Counter update and event generation. Entering TRACK from IDLE leaves the
  // counter at 0, so the first tracked sample always counts as 1.
  always_comb begin
    w_cnt_next = r_cnt;
    w_event    = 1'b0;
    if (!en) begin
      w_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE: w_cnt_next = '0;
        TRACK: begin
          if (w_same)
            w_cnt_next = (r_cnt == CNT_TARGET) ? r_cnt : r_cnt + 1'b1;
          else
            w_cnt_next = CW'(1);
          w_event = (w_cnt_next == CNT_TARGET);
        end
        LOCKED: if (!w_same) w_cnt_next = CW'(1);
        default: w_cnt_next = '0;
      endcase
    end
  end

  // Result holding register. An event in the same cycle as an acceptance
  // reloads the result, so valid stays high without flagging overrun.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_digit   <= 4'h0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_blank   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (r_valid && ready) r_valid <= 1'b0;
      if (w_event) begin
        if (r_sample == SEG_BLANK) begin
          r_blank <= 1'b1;
        end else begin
          r_blank <= 1'b0;
          r_valid <= 1'b1;
          r_digit <= w_hit ? w_lut_digit : 4'h0;
          r_err   <= ~w_hit;
          if (r_valid && !ready) r_overrun <= 1'b1;
        end
      end
    end
  end

  assign digit   = r_digit;
  assign valid   = r_valid;
  assign err     = r_err;
  assign blank   = r_blank;
  assign overrun = r_overrun;

endmodule
